sync_updown_counter: RTL and testbench

SYNC_UPDOWN_COUNTER -- requirements
Module: sync_updown_counter

---
 rtl/sync_updown_counter_pkg.sv | 21 ++
 rtl/sync_updown_counter_bin2gray.sv | 12 +
 rtl/sync_updown_counter.sv | 121 ++++++++++++
 tb/tb_sync_updown_counter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sync_updown_counter_pkg.sv
// Shared counters package: default geometry, direction encodings and the
// per-edge operation code used by the up/down counter.
package sync_updown_counter_pkg;

    localparam int DEFAULT_WIDTH   = 5;
    localparam int DEFAULT_MODULUS = 32;

    // Direction encodings for the 'up' input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // What the counter does on a given clock edge, already priority-resolved.
    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_CLEAR  = 3'd1,
        OP_PRESET = 3'd2,
        OP_LOAD   = 3'd3,
        OP_COUNT  = 3'd4
    } op_e;

endpackage

// File: rtl/sync_updown_counter_bin2gray.sv
// Binary to reflected-Gray conversion, purely combinational.
module bin2gray #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    // Each Gray bit is the XOR of adjacent binary bits; MSB passes through.
    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/sync_updown_counter.sv
// Modulo-MODULUS synchronous up/down counter with clear, preset, parallel
// load (range-checked), terminal count, wrap pulse and Gray-coded output.
// MODULUS must lie in 2..2**WIDTH. Comparisons and next-value arithmetic are
// carried one bit wider than the count so MODULUS = 2**WIDTH cannot overflow.
module sync_updown_counter
    import sync_updown_counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             preset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    localparam int            XW    = WIDTH + 1;
    localparam logic [XW-1:0] MAX_X = XW'(MODULUS - 1);
    localparam logic [XW-1:0] MOD_X = XW'(MODULUS);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_load_err;

    logic [XW-1:0]    w_count_x;
    logic [XW-1:0]    w_load_x;
    logic [XW-1:0]    w_next_x;
    logic [WIDTH-1:0] w_max;
    logic [WIDTH-1:0] w_next_count;
    logic [WIDTH-1:0] w_load_count;
    logic [WIDTH-1:0] w_gray;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_load_bad;
    logic             w_tc;
    logic             w_unused;
    op_e              w_op;

    assign w_count_x  = {1'b0, r_count};
    assign w_load_x   = {1'b0, load_val};
    assign w_max      = MAX_X[WIDTH-1:0];
    assign w_at_max   = (w_count_x == MAX_X);
    assign w_at_zero  = (w_count_x == '0);
    assign w_load_bad = (w_load_x >= MOD_X);

    // Terminal count: the next enabled count step in the current direction wraps.
    assign w_tc = en & (((up == DIR_UP)   & w_at_max) |
                        ((up == DIR_DOWN) & w_at_zero));

    // Next value of an enabled count step, wrapping at both ends of the range.
    always_comb begin
        w_next_x = w_count_x;
        if (up == DIR_UP) begin
            w_next_x = w_at_max ? '0 : (w_count_x + XW'(1));
        end else begin
            w_next_x = w_at_zero ? MAX_X : (w_count_x - XW'(1));
        end
    end

    // The extra arithmetic bit is always zero after the wrap selection.
    assign w_next_count = w_next_x[WIDTH-1:0];
    assign w_unused     = w_next_x[WIDTH];

    // Out-of-range loads saturate to the top of the count range.
    assign w_load_count = w_load_bad ? w_max : load_val;

    // Resolve control priority for this edge: clear > preset > load > en.
    always_comb begin
        w_op = OP_HOLD;
        if (clear) begin
            w_op = OP_CLEAR;
        end else if (preset) begin
            w_op = OP_PRESET;
        end else if (load) begin
            w_op = OP_LOAD;
        end else if (en) begin
            w_op = OP_COUNT;
        end
    end

    // Count register plus the one-cycle wrap and load-error pulses.
    always_ff @(posedge clk) begin
        r_wrap     <= 1'b0;
        r_load_err <= 1'b0;
        case (w_op)
            OP_CLEAR:  r_count <= '0;
            OP_PRESET: r_count <= w_max;
            OP_LOAD: begin
                r_count    <= w_load_count;
                r_load_err <= w_load_bad;
            end
            OP_COUNT: begin
                r_count <= w_next_count;
                r_wrap  <= w_tc;
            end
            default:   r_count <= r_count;
        endcase
    end

    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .i_bin  (r_count),
        .o_gray (w_gray)
    );

    assign count    = r_count;
    assign gray     = w_gray;
    assign tc       = w_tc;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: a MODULUS=10 instance and a MODULUS=32
// instance share the stimulus; each expected entry names which one it checks.
module tb_sync_updown_counter;

  localparam int W  = 5;
  localparam int EW = 14;  // {sel, count[5], gray[5], tc, wrap, load_err}

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         preset = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] count10, gray10, count32, gray32;
  logic         tc10, wrap10, err10, tc32, wrap32, err32;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(W), .MODULUS(10)) dut10 (
    .clk(clk), .clear(clear), .preset(preset), .en(en), .up(up),
    .load(load), .load_val(load_val), .count(count10), .gray(gray10),
    .tc(tc10), .wrap(wrap10), .load_err(err10)
  );

  sync_updown_counter #(.WIDTH(W), .MODULUS(32)) dut32 (
    .clk(clk), .clear(clear), .preset(preset), .en(en), .up(up),
    .load(load), .load_val(load_val), .count(count32), .gray(gray32),
    .tc(tc32), .wrap(wrap32), .load_err(err32)
  );

  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of controls and queue what the outputs must show after
  // the following rising edge (controls are still held at that point).
  task automatic vecg(input int s, input int c, input int p, input int l, input int lv,
                      input int e, input int u, input int ec, input int eg,
                      input int etc, input int ew, input int eerr);
    @(negedge clk);
    clear    = 1'(c);
    preset   = 1'(p);
    load     = 1'(l);
    load_val = W'(lv);
    en       = 1'(e);
    up       = 1'(u);
    exp_q.push_back({1'(s), W'(ec), W'(eg), 1'(etc), 1'(ew), 1'(eerr)});
  endtask

  task automatic vec(input int s, input int c, input int p, input int l, input int lv,
                     input int e, input int u, input int ec,
                     input int etc, input int ew, input int eerr);
    vecg(s, c, p, l, lv, e, u, ec, int'(to_gray(W'(ec))), etc, ew, eerr);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    logic [W-1:0]  ac, ag;
    logic          at, aw, ae;
    string         tag;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[13]) begin
          ac = count32; ag = gray32; at = tc32; aw = wrap32; ae = err32; tag = "m32";
        end else begin
          ac = count10; ag = gray10; at = tc10; aw = wrap10; ae = err10; tag = "m10";
        end
        chk({tag, ".count"},    8'(ac), 8'(e[12:8]));
        chk({tag, ".gray"},     8'(ag), 8'(e[7:3]));
        chk({tag, ".tc"},       8'(at), 8'(e[2]));
        chk({tag, ".wrap"},     8'(aw), 8'(e[1]));
        chk({tag, ".load_err"}, 8'(ae), 8'(e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    //   s c p l lv e u  cnt tc w err
    // MODULUS=10: clear wins over a pending load
    vec(0, 1,0,1, 7, 0,0,  0, 0,0,0);
    // after clear, tc follows en & ~up
    vec(0, 1,0,0, 0, 1,0,  0, 1,0,0);
    // up count 1..9, tc at 9
    for (int i = 1; i <= 9; i++) vec(0, 0,0,0, 0, 1,1, i, int'(i == 9), 0,0);
    vec(0, 0,0,0, 0, 1,1,  0, 0,1,0);   // wrap 9 -> 0
    vec(0, 0,0,0, 0, 1,1,  1, 0,0,0);   // pulse lasts one cycle
    // down wrap
    vec(0, 0,0,1, 0, 0,0,  0, 0,0,0);   // load 0
    vec(0, 0,0,0, 0, 1,0,  9, 0,1,0);   // 0 -> 9 with wrap
    for (int i = 8; i >= 0; i--) vec(0, 0,0,0, 0, 1,0, i, int'(i == 0), 0,0);
    vec(0, 0,0,0, 0, 0,0,  0, 0,0,0);   // hold
    // load range checks
    vec(0, 0,0,1,12, 0,0,  9, 0,0,1);
    vec(0, 0,0,0, 0, 0,0,  9, 0,0,0);
    vec(0, 0,0,1,10, 0,0,  9, 0,0,1);   // first illegal value
    vec(0, 0,0,1, 9, 0,0,  9, 0,0,0);   // last legal value
    vec(0, 0,0,1,31, 0,0,  9, 0,0,1);
    // priority
    vec(0, 1,1,1, 5, 1,1,  0, 0,0,0);   // clear beats everything
    vec(0, 0,1,1,12, 1,0,  9, 0,0,0);   // preset beats illegal load
    vec(0, 0,0,1, 3, 1,1,  3, 0,0,0);   // load beats en
    // direction changes
    vec(0, 0,0,0, 0, 1,1,  4, 0,0,0);
    vec(0, 0,0,0, 0, 1,0,  3, 0,0,0);
    vec(0, 0,0,0, 0, 1,1,  4, 0,0,0);
    // load at terminal count never raises wrap
    vec(0, 0,0,1, 9, 0,0,  9, 0,0,0);
    vec(0, 0,0,1, 2, 1,1,  2, 0,0,0);
    // clear aborts a wrapping count
    vec(0, 0,0,1, 9, 0,0,  9, 0,0,0);
    vec(0, 1,0,0, 0, 1,1,  0, 0,0,0);
    vec(0, 0,0,0, 0, 0,0,  0, 0,0,0);
    // clear aborts an illegal load: no residual load_err
    vec(0, 1,0,1,12, 0,0,  0, 0,0,0);
    vec(0, 0,0,0, 0, 0,0,  0, 0,0,0);
    // preset at count 0 while counting down never raises wrap
    vec(0, 0,1,0, 0, 1,0,  9, 0,0,0);
    vec(0, 0,0,0, 0, 0,0,  9, 0,0,0);

    //    s c p l lv e u  cnt gray      tc w err   MODULUS=32, hand-computed Gray
    vecg(1, 1,0,0, 0, 0,0,  0, 5'b00000, 0,0,0);
    vecg(1, 0,0,1,31, 0,0, 31, 5'b10000, 0,0,0);
    vecg(1, 0,0,1,31, 1,1, 31, 5'b10000, 1,0,0);
    vecg(1, 0,0,0, 0, 1,1,  0, 5'b00000, 0,1,0);
    vecg(1, 0,0,0, 0, 1,1,  1, 5'b00001, 0,0,0);
    vecg(1, 0,0,0, 0, 1,1,  2, 5'b00011, 0,0,0);
    vecg(1, 0,0,0, 0, 1,1,  3, 5'b00010, 0,0,0);
    vecg(1, 0,0,1, 0, 0,0,  0, 5'b00000, 0,0,0);
    vecg(1, 0,0,0, 0, 1,0, 31, 5'b10000, 0,1,0);
    vecg(1, 0,0,0, 0, 1,0, 30, 5'b10001, 0,0,0);
    vecg(1, 0,0,0, 0, 0,0, 30, 5'b10001, 0,0,0);

    // drain the scoreboard with a bounded wait
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
